// File: rtl/snake_pio_pkg.sv
// snake_pio_pkg: register map, status field layout and pulse timer width for the snake output PIO
package snake_pio_pkg;
  localparam int PULSE_W = 16;
  localparam int STATUS_ACTIVE_BIT = 31;
  localparam int STATUS_COUNT_W = 16;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PWIDTH = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_PULSE  = 3'd6;
endpackage

// File: rtl/snake_pulse_timer.sv
// snake_pulse_timer: reloadable down-counter that flags the last cycle of a timed pulse
module snake_pulse_timer
  import snake_pio_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [PULSE_W-1:0] width,
  output logic [PULSE_W-1:0] cnt,
  output logic               expire,
  output logic               active
);
  assign active = cnt != '0;
  assign expire = cnt == PULSE_W'(1);
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (load) cnt <= (width == '0) ? PULSE_W'(1) : width;
    else if (active) cnt <= cnt - PULSE_W'(1);
  end
endmodule

// File: rtl/snake_hardware_out.sv
// snake_hardware_out: Avalon-MM output PIO with set/clear, timed pulse and change tracking
module snake_hardware_out
  import snake_pio_pkg::*;
#(
  parameter int                  DATA_WIDTH    = 31,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [PULSE_W-1:0]  PULSE_DEFAULT = 16'd1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_changed
);
  logic wr, expire, active, changed, unused_bits;
  logic [DATA_WIDTH-1:0] wd, bits, out_exp, bits_exp, out_nxt, bits_nxt;
  logic [PULSE_W-1:0] pulse_width, pulse_cnt;
  logic [STATUS_COUNT_W-1:0] change_count;
  logic [31:0] status, rd_nxt;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];
  assign unused_bits = ^{writedata, pulse_cnt};
  snake_pulse_timer u_timer (
    .clk(clk), .reset(reset),
    .load(wr && address == ADDR_PULSE),
    .clear(wr && address == ADDR_DATA),
    .width(pulse_width), .cnt(pulse_cnt), .expire(expire), .active(active)
  );
  // expiry is applied first so a same-cycle write overrides it
  always_comb begin
    out_exp  = expire ? out_port & ~bits : out_port;
    bits_exp = expire ? '0 : bits;
    out_nxt  = !wr ? out_exp :
               address == ADDR_DATA ? wd :
               (address == ADDR_OUTSET || address == ADDR_PULSE) ? out_exp | wd :
               address == ADDR_OUTCLR ? out_exp & ~wd : out_exp;
    bits_nxt = !wr ? bits_exp :
               address == ADDR_DATA ? '0 :
               address == ADDR_OUTCLR ? bits_exp & ~wd :
               address == ADDR_PULSE ? bits_exp | wd : bits_exp;
    changed  = out_nxt != out_port;
    status   = (32'(active) << STATUS_ACTIVE_BIT) | 32'(change_count);
    rd_nxt   = address == ADDR_DATA ? 32'(out_port) :
               address == ADDR_STATUS ? status :
               address == ADDR_PWIDTH ? 32'(pulse_width) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port     <= RESET_VALUE;
      bits         <= '0;
      readdata     <= '0;
      out_changed  <= 1'b0;
      change_count <= '0;
      pulse_width  <= PULSE_DEFAULT;
    end else begin
      out_port     <= out_nxt;
      bits         <= bits_nxt;
      readdata     <= rd_nxt;
      out_changed  <= changed;
      change_count <= change_count + STATUS_COUNT_W'(changed);
      if (wr && address == ADDR_PWIDTH) pulse_width <= writedata[PULSE_W-1:0];
    end
  end
endmodule

// File: tb/tb_snake_hardware_out.sv
// tb_snake_hardware_out: directed scoreboard bench for the snake output PIO
module tb_snake_hardware_out;
  logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0] address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [30:0] out_port;
  logic out_changed;
  logic [31:0] exp_q[$];
  int checks = 0, failures = 0;

  snake_hardware_out dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_changed(out_changed)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
    push(e);
    address = a;
    @(negedge clk);
    chk(tag, readdata);
  endtask

  task automatic chk_out(input logic [31:0] e, input string tag);
    push(e);
    chk(tag, 32'(out_port));
  endtask

  task automatic chk_chg(input logic e, input string tag);
    push({31'b0, e});
    chk(tag, {31'b0, out_changed});
  endtask

  initial begin
    repeat (2) tick();
    chk_out(32'h0, "rst_out");
    push(32'h0); chk("rst_readdata", readdata);
    chk_chg(1'b0, "rst_changed");
    reset = 1'b0;
    rd(3'd1, 32'h0, "rst_status");
    rd(3'd2, 32'd1000, "rst_pwidth");

    wr(3'd0, 32'h15);
    chk_out(32'h15, "data_out");
    chk_chg(1'b1, "data_strobe");
    tick();
    chk_chg(1'b0, "data_strobe_1cyc");
    rd(3'd0, 32'h15, "data_read");
    wr(3'd0, 32'h15);
    chk_chg(1'b0, "same_write_no_strobe");

    wr(3'd4, 32'h100);
    chk_out(32'h115, "outset");
    wr(3'd5, 32'h001);
    chk_out(32'h114, "outclr");
    rd(3'd4, 32'h0, "outset_reads_zero");
    rd(3'd1, 32'h3, "status_count3");

    wr(3'd2, 32'h4);
    rd(3'd2, 32'h4, "pwidth_rb");
    wr(3'd6, 32'h8000);
    address = 3'd1;
    for (int i = 0; i < 6; i++) begin
      push({31'b0, i < 4}); chk("pulse_bit15", {31'b0, out_port[15]});
      if (i >= 1) begin
        push({31'b0, i <= 4}); chk("pulse_active", {31'b0, readdata[31]});
      end
      tick();
    end
    chk_out(32'h114, "pulse_done");

    wr(3'd6, 32'h1);
    tick();
    wr(3'd6, 32'h2);
    for (int i = 0; i < 5; i++) begin
      push(i < 4 ? 32'h3 : 32'h0); chk("retrigger_bits", {30'b0, out_port[1:0]});
      tick();
    end

    wr(3'd2, 32'h0);
    wr(3'd6, 32'h8);
    chk_out(32'h11C, "pw0_high");
    tick();
    chk_out(32'h114, "pw0_low");
    rd(3'd1, 32'hA, "status_count10");

    wr(3'd2, 32'h2);
    wr(3'd6, 32'h1);
    tick();
    wr(3'd4, 32'h1);
    chk_out(32'h115, "set_on_expiry");
    tick();
    chk_out(32'h115, "set_on_expiry_hold");
    rd(3'd1, 32'hB, "status_after_expiry");
    wr(3'd0, 32'h114);

    wr(3'd2, 32'h4);
    wr(3'd6, 32'h20);
    tick();
    wr(3'd0, 32'h134);
    chk_chg(1'b0, "cancel_no_strobe");
    repeat (4) tick();
    chk_out(32'h134, "cancel_holds");
    rd(3'd1, 32'hD, "cancel_inactive");

    wr(3'd6, 32'h40);
    chk_out(32'h174, "pre_reset_pulse");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out(32'h0, "reset_mid_pulse");
    chk_chg(1'b0, "reset_mid_changed");
    rd(3'd1, 32'h0, "reset_mid_status");
    rd(3'd2, 32'd1000, "reset_mid_pwidth");

    address = 3'd0; chipselect = 1'b1; write_n = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      writedata = {31'b0, ~i[0]};
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd1, 32'hFFFF, "count_ffff");
    wr(3'd0, 32'h0);
    rd(3'd1, 32'h0, "count_wrap");

    wr(3'd0, 32'hFFFF_FFFF);
    chk_out(32'h7FFF_FFFF, "width_mask");
    rd(3'd0, 32'h7FFF_FFFF, "width_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
